// File: rtl/i2c_target_rx.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_target_rx
//  Purpose  : Write-only I2C target. Oversamples SCL/SDA on clk_i, detects
//             START/STOP, matches a 7-bit address, drives ACK on SDA and
//             delivers each received data byte on a one-cycle strobe.
//  Options  : I2C_CTRL_DECODE_EN - decode SSD1306 control bytes (Co, D/C#)
//             and tag payload bytes through rx_is_data_o.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_target_rx #(
   parameter logic [6:0]  TARGET_ADDR = 7'h3C,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe_o,
   input  logic       nack_req_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       rx_first_o,
   output logic       rx_is_data_o,
   output logic       busy_o,
   output logic       start_det_o,
   output logic       stop_det_o
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ADDR     = 3'd1;
   localparam logic [2:0] S_ADDR_ACK = 3'd2;
   localparam logic [2:0] S_DATA     = 3'd3;
   localparam logic [2:0] S_DATA_ACK = 3'd4;
   localparam logic [2:0] S_IGNORE   = 3'd5;

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;

   logic [2:0] state_q;
   logic [2:0] state_d;
   logic [2:0] bit_cnt_q;
   logic [7:0] shift_q;
   logic       oe_q;
   logic       byte_done_q;
   logic       first_q;
   logic       busy_q;
   logic [7:0] rx_data_q;
   logic       rx_valid_q;
   logic       rx_first_q;
   logic       rx_is_data_q;
   logic       start_det_q;
   logic       stop_det_q;

   logic w_scl;
   logic w_sda;
   logic w_scl_rise;
   logic w_scl_fall;
   logic w_start;
   logic w_stop;
   logic w_byte_full;
   logic w_addr_hit;
   logic w_addr_miss;
   logic w_ack_on;
   logic w_ack_off;
   logic w_deliver;
   logic w_drop;
   logic w_is_data;

   // Synchronize the pad inputs and keep one previous sample for edge detect
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
         sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
      end
   end

   assign w_scl       = scl_sync_q[SYNC_STAGES-1];
   assign w_sda       = sda_sync_q[SYNC_STAGES-1];
   assign w_scl_rise  = w_scl & ~scl_prev_q;
   assign w_scl_fall  = ~w_scl & scl_prev_q;
   // SDA may only move while SCL is high for bus conditions
   assign w_start     = w_scl & scl_prev_q & sda_prev_q & ~w_sda;
   assign w_stop      = w_scl & scl_prev_q & ~sda_prev_q & w_sda;
   assign w_byte_full = w_scl_rise && (bit_cnt_q == 3'd7);

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic and per-cycle action decode
   always_comb begin
      state_d     = state_q;
      w_addr_hit  = 1'b0;
      w_addr_miss = 1'b0;
      w_ack_on    = 1'b0;
      w_ack_off   = 1'b0;
      w_deliver   = 1'b0;
      w_drop      = 1'b0;
      if (w_start) begin
         state_d = S_ADDR;
      end else if (w_stop) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_ADDR: begin
               // Address byte is the 7 bits already shifted plus R/W on this rise
               if (w_byte_full) begin
                  if ((shift_q[6:0] == TARGET_ADDR) && !w_sda) begin
                     w_addr_hit = 1'b1;
                     state_d    = S_ADDR_ACK;
                  end else begin
                     w_addr_miss = 1'b1;
                     state_d     = S_IGNORE;
                  end
               end
            end
            S_ADDR_ACK: begin
               // First fall ends the 8th clock (drive ACK), second ends the 9th
               if (w_scl_fall) begin
                  if (!oe_q) begin
                     w_ack_on = 1'b1;
                  end else begin
                     w_ack_off = 1'b1;
                     state_d   = S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_scl_fall && byte_done_q) begin
                  if (!nack_req_i) begin
                     w_deliver = 1'b1;
                     state_d   = S_DATA_ACK;
                  end else begin
                     w_drop  = 1'b1;
                     state_d = S_IGNORE;
                  end
               end
            end
            S_DATA_ACK: begin
               if (w_scl_fall) begin
                  w_ack_off = 1'b1;
                  state_d   = S_DATA;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // FSM outputs; a bus condition releases SDA in the cycle it is seen
   always_comb begin
      sda_oe_o     = oe_q & ~(w_start | w_stop);
      rx_data_o    = rx_data_q;
      rx_valid_o   = rx_valid_q;
      rx_first_o   = rx_first_q;
      rx_is_data_o = rx_is_data_q;
      busy_o       = busy_q;
      start_det_o  = start_det_q;
      stop_det_o   = stop_det_q;
   end

   // Shift register, bit counter, ACK driver and receive strobes
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'h00;
         oe_q         <= 1'b0;
         byte_done_q  <= 1'b0;
         first_q      <= 1'b0;
         busy_q       <= 1'b0;
         rx_data_q    <= 8'h00;
         rx_valid_q   <= 1'b0;
         rx_first_q   <= 1'b0;
         rx_is_data_q <= 1'b0;
         start_det_q  <= 1'b0;
         stop_det_q   <= 1'b0;
      end else begin
         rx_valid_q   <= 1'b0;
         rx_first_q   <= 1'b0;
         rx_is_data_q <= 1'b0;
         start_det_q  <= w_start;
         stop_det_q   <= w_stop;
         if (w_start || w_stop) begin
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            oe_q        <= 1'b0;
            if (w_stop) begin
               busy_q <= 1'b0;
            end
         end else begin
            if (w_scl_rise && ((state_q == S_ADDR) || (state_q == S_DATA))) begin
               shift_q   <= {shift_q[6:0], w_sda};
               bit_cnt_q <= bit_cnt_q + 3'd1;
               if ((state_q == S_DATA) && (bit_cnt_q == 3'd7)) begin
                  byte_done_q <= 1'b1;
               end
            end
            if (w_addr_hit) begin
               busy_q <= 1'b1;
            end
            if (w_addr_miss) begin
               busy_q <= 1'b0;
            end
            if (w_ack_on) begin
               oe_q    <= 1'b1;
               first_q <= 1'b1;
            end
            if (w_ack_off) begin
               oe_q <= 1'b0;
            end
            if (w_deliver) begin
               oe_q         <= 1'b1;
               byte_done_q  <= 1'b0;
               rx_data_q    <= shift_q;
               rx_valid_q   <= 1'b1;
               rx_first_q   <= first_q;
               rx_is_data_q <= w_is_data;
               first_q      <= 1'b0;
            end
            if (w_drop) begin
               byte_done_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         end
      end
   end

`ifdef I2C_CTRL_DECODE_EN
   logic ctrl_next_q;
   logic stream_q;
   logic dc_q;

   assign w_is_data = ctrl_next_q ? 1'b0 : dc_q;

   // Track whether the next byte is a control byte and the current D/C# tag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctrl_next_q <= 1'b1;
         stream_q    <= 1'b0;
         dc_q        <= 1'b0;
      end else if (w_ack_on && (state_q == S_ADDR_ACK)) begin
         ctrl_next_q <= 1'b1;
         stream_q    <= 1'b0;
         dc_q        <= 1'b0;
      end else if (w_deliver) begin
         if (ctrl_next_q) begin
            // Co = 0 turns the rest of the transfer into payload
            dc_q        <= shift_q[6];
            stream_q    <= ~shift_q[7];
            ctrl_next_q <= 1'b0;
         end else if (!stream_q) begin
            ctrl_next_q <= 1'b1;
         end
      end
   end
`else
   assign w_is_data = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_target_rx
//  Purpose  : Self-checking bench for i2c_target_rx: table of write
//             transfers plus hand sequences for repeated START, async reset
//             during ACK and control-byte tagging.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target_rx;

   localparam int Q = 8;   // clk cycles per quarter SCL period

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       nack_req = 1'b0;
   logic       sda_line;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_first;
   logic       rx_is_data;
   logic       busy;
   logic       start_det;
   logic       stop_det;

   assign sda_line = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_target_rx #(
      .TARGET_ADDR (7'h3C),
      .SYNC_STAGES (2)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .scl_i        (scl_m),
      .sda_i        (sda_line),
      .sda_oe_o     (sda_oe),
      .nack_req_i   (nack_req),
      .rx_data_o    (rx_data),
      .rx_valid_o   (rx_valid),
      .rx_first_o   (rx_first),
      .rx_is_data_o (rx_is_data),
      .busy_o       (busy),
      .start_det_o  (start_det),
      .stop_det_o   (stop_det)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: record strobed bytes and count events
   logic [7:0] got_d [$];
   logic       got_f [$];
   logic       got_i [$];
   int n_start = 0, n_stop = 0, n_oe = 0, n_busy = 0, n_qual = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) begin
            got_d.push_back(rx_data);
            got_f.push_back(rx_first);
            got_i.push_back(rx_is_data);
         end else if (rx_first || rx_is_data) begin
            n_qual++;
         end
         if (start_det) n_start++;
         if (stop_det)  n_stop++;
         if (sda_oe)    n_oe++;
         if (busy)      n_busy++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic wq(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(2*Q);
      sda_m = 1'b0; wq(2*Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b1; wq(2*Q);
      sda_m = 1'b1; wq(2*Q);
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;    wq(Q);
      scl_m = 1'b1; wq(2*Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic acked);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      acked = (sda_line == 1'b0);
      wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   typedef struct {
      string           name;
      logic [7:0]      addr;
      int              nb;
      logic [2:0][7:0] d;
      logic [2:0]      nack_mask;
      logic            exp_aack;
      logic [2:0]      exp_dack;
      int              exp_nvalid;
      logic            exp_busy_pre;
      logic            exp_oe_seen;
   } vec_t;

   function automatic vec_t mk(input string nm, input logic [7:0] a, input int nb,
                               input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                               input logic [2:0] nmask, input logic aack, input logic [2:0] dack,
                               input int nv, input logic bpre, input logic oes);
      vec_t v;
      v.name = nm; v.addr = a; v.nb = nb;
      v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
      v.nack_mask = nmask; v.exp_aack = aack; v.exp_dack = dack;
      v.exp_nvalid = nv; v.exp_busy_pre = bpre; v.exp_oe_seen = oes;
      return v;
   endfunction

   vec_t vt [4];

   initial begin
      logic       a;
      logic [2:0] dack;
      int         b0, s0, p0, oe0, bz0, nv;
      logic [7:0] byte_v;
      logic [2:0] exp_isd;

      vt[0] = mk("write2",     8'h78, 2, 8'h00, 8'hAE, 8'h00, 3'b000, 1'b1, 3'b011, 2, 1'b1, 1'b1);
      vt[1] = mk("wrong_addr", 8'h7A, 1, 8'h55, 8'h00, 8'h00, 3'b000, 1'b0, 3'b000, 0, 1'b0, 1'b0);
      vt[2] = mk("read_req",   8'h79, 1, 8'h33, 8'h00, 8'h00, 3'b000, 1'b0, 3'b000, 0, 1'b0, 1'b0);
      vt[3] = mk("nack_2nd",   8'h78, 3, 8'hA5, 8'h12, 8'h34, 3'b010, 1'b1, 3'b001, 1, 1'b0, 1'b1);

      // Reset state
      rst_n = 1'b0;
      wq(5);
      check("rst_sda_oe",   {31'd0, sda_oe},    32'd0);
      check("rst_rx_valid", {31'd0, rx_valid},  32'd0);
      check("rst_busy",     {31'd0, busy},      32'd0);
      check("rst_start",    {31'd0, start_det}, 32'd0);
      check("rst_stop",     {31'd0, stop_det},  32'd0);
      check("rst_rx_data",  {24'd0, rx_data},   32'd0);
      rst_n = 1'b1;
      wq(10);

      // Table-driven transfers
      for (int v = 0; v < 4; v++) begin
         b0 = got_d.size(); s0 = n_start; p0 = n_stop; oe0 = n_oe; bz0 = n_busy;
         dack = 3'b000;
         bus_start();
         send_byte(vt[v].addr, a);
         check({vt[v].name, "_addr_ack"}, {31'd0, a}, {31'd0, vt[v].exp_aack});
         for (int k = 0; k < vt[v].nb; k++) begin
            logic ak;
            nack_req = vt[v].nack_mask[k];
            send_byte(vt[v].d[k], ak);
            dack[k] = ak;
            nack_req = 1'b0;
         end
         check({vt[v].name, "_data_ack"}, {29'd0, dack}, {29'd0, vt[v].exp_dack});
         check({vt[v].name, "_busy_pre_stop"}, {31'd0, busy}, {31'd0, vt[v].exp_busy_pre});
         bus_stop();
         wq(8);
         check({vt[v].name, "_busy_after"}, {31'd0, busy}, 32'd0);
         check({vt[v].name, "_busy_seen"}, {31'd0, (n_busy != bz0)}, {31'd0, vt[v].exp_aack});
         check({vt[v].name, "_oe_seen"}, {31'd0, (n_oe != oe0)}, {31'd0, vt[v].exp_oe_seen});
         check({vt[v].name, "_starts"}, n_start - s0, 32'd1);
         check({vt[v].name, "_stops"}, n_stop - p0, 32'd1);
         nv = got_d.size() - b0;
         check({vt[v].name, "_nvalid"}, nv, vt[v].exp_nvalid);
         for (int i = 0; i < vt[v].exp_nvalid && i < nv; i++) begin
            check({vt[v].name, "_data"},  {24'd0, got_d[b0+i]}, {24'd0, vt[v].d[i]});
            check({vt[v].name, "_first"}, {31'd0, got_f[b0+i]}, (i == 0) ? 32'd1 : 32'd0);
            check({vt[v].name, "_isdat"}, {31'd0, got_i[b0+i]}, 32'd0);
         end
      end

      // Repeated START after 4 bits of a data byte
      b0 = got_d.size(); s0 = n_start;
      bus_start();
      send_byte(8'h78, a);
      check("rs_addr1_ack", {31'd0, a}, 32'd1);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      bus_start();
      send_byte(8'h78, a);
      check("rs_addr2_ack", {31'd0, a}, 32'd1);
      send_byte(8'h40, a);
      check("rs_data_ack", {31'd0, a}, 32'd1);
      bus_stop();
      wq(8);
      check("rs_starts", n_start - s0, 32'd2);
      nv = got_d.size() - b0;
      check("rs_nvalid", nv, 32'd1);
      if (nv >= 1) begin
         check("rs_data",  {24'd0, got_d[b0]}, 32'h40);
         check("rs_first", {31'd0, got_f[b0]}, 32'd1);
      end

      // Asynchronous reset while ACK is being driven for the address
      b0 = got_d.size();
      bus_start();
      byte_v = 8'h78;
      for (int i = 7; i >= 0; i--) send_bit(byte_v[i]);
      for (int i = 0; i < 64 && sda_oe !== 1'b1; i++) wq(1);
      check("arst_oe_before", {31'd0, sda_oe}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_oe_async", {31'd0, sda_oe}, 32'd0);
      check("arst_busy",     {31'd0, busy},   32'd0);
      scl_m = 1'b1; sda_m = 1'b1;
      wq(4);
      rst_n = 1'b1;
      wq(20);
      check("arst_no_strobe", got_d.size() - b0, 32'd0);
      check("arst_oe_after",  {31'd0, sda_oe}, 32'd0);
      check("arst_busy_after", {31'd0, busy}, 32'd0);
      bus_start();
      send_byte(8'h78, a);
      check("arst_readdr_ack", {31'd0, a}, 32'd1);
      send_byte(8'h11, a);
      bus_stop();
      wq(8);
      nv = got_d.size() - b0;
      check("arst_nvalid", nv, 32'd1);
      if (nv >= 1) begin
         check("arst_data",  {24'd0, got_d[b0]}, 32'h11);
         check("arst_first", {31'd0, got_f[b0]}, 32'd1);
      end

      // Control-byte stream: 0x40 (Co=0, D/C#=1) then two payload bytes
`ifdef I2C_CTRL_DECODE_EN
      exp_isd = 3'b110;
`else
      exp_isd = 3'b000;
`endif
      b0 = got_d.size();
      bus_start();
      send_byte(8'h78, a);
      send_byte(8'h40, a);
      send_byte(8'hFF, a);
      send_byte(8'h0F, a);
      check("ctl_last_ack", {31'd0, a}, 32'd1);
      bus_stop();
      wq(8);
      nv = got_d.size() - b0;
      check("ctl_nvalid", nv, 32'd3);
      if (nv >= 3) begin
         check("ctl_d0", {24'd0, got_d[b0]},   32'h40);
         check("ctl_d1", {24'd0, got_d[b0+1]}, 32'hFF);
         check("ctl_d2", {24'd0, got_d[b0+2]}, 32'h0F);
         check("ctl_f0", {31'd0, got_f[b0]},   32'd1);
         check("ctl_f1", {31'd0, got_f[b0+1]}, 32'd0);
         check("ctl_i0", {31'd0, got_i[b0]},   {31'd0, exp_isd[0]});
         check("ctl_i1", {31'd0, got_i[b0+1]}, {31'd0, exp_isd[1]});
         check("ctl_i2", {31'd0, got_i[b0+2]}, {31'd0, exp_isd[2]});
      end

      check("qualifiers_idle_zero", n_qual, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- Synthesizable I2C target (responder) for the OLED I2C link; the receiving end of the master's write traffic.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, drives ACK, and delivers received bytes on a one-cycle valid strobe.
- Used as an on-chip loopback target and as the bench target replacing forced-ACK stubs.

Parameters:
- TARGET_ADDR, 7'h3C, 7-bit I2C address answered.
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (min 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- scl_in  input  1  raw SCL from pad.
- sda_in  input  1  raw SDA from pad.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- nack_req  input  1  1 = NACK the next data byte.
- rx_data  output  8  last received data byte.
- rx_valid  output  1  one-cycle strobe, rx_data new.
- rx_first  output  1  qualifies rx_valid: first data byte after the address.
- rx_is_data  output  1  qualifies rx_valid: byte is a display-data byte (see Optional Feature).
- busy  output  1  1 from address match to STOP/mismatch.
- start_det  output  1  one-cycle pulse per START/repeated START.
- stop_det  output  1  one-cycle pulse per STOP.

Behaviour:
- Reset (reset = 0): all outputs 0; state IDLE; synchronizers load 1 (bus idle). Effect is immediate, including mid-ACK: sda_oe drops asynchronously.
- Inputs pass through SYNC_STAGES flops, then one edge-detect register. Event latency from pad to internal edge is SYNC_STAGES+1 clk.
- START: SDA fall while synced SCL = 1.
  - Pulse start_det.
  - Clear bit counter.
  - Go to ADDR from any state; repeated START included.
- STOP: SDA rise while SCL = 1.
  - Pulse stop_det.
  - Release sda_oe.
  - busy = 0.
  - Go to IDLE from any state.
- Data bits are sampled on SCL rising edges, MSB first. The 3-bit counter wraps 7 -> 0 at each byte boundary.
- States:
  - IDLE: ignore SCL; wait for START.
  - ADDR: shift 8 bits. After the 8th rise:
    - if addr[7:1] == TARGET_ADDR and R/W = 0: go to ADDR_ACK and set busy = 1.
    - otherwise: go to IGNORE. Read requests are NACKed; this block is write-only.
  - ADDR_ACK: on the next SCL fall, set sda_oe = 1. On the following SCL fall, set sda_oe = 0 and go to DATA. Set the first-byte flag.
  - DATA: shift 8 bits. On the SCL fall after the 8th rise:
    - if nack_req = 0: set sda_oe = 1, latch rx_data, pulse rx_valid in that same clk with rx_first = first-byte flag, then clear the flag. Go to DATA_ACK.
    - if nack_req = 1: leave sda_oe = 0, no rx_valid, busy = 0. Go to IGNORE.
  - DATA_ACK: on the next SCL fall, set sda_oe = 0 and return to DATA.
  - IGNORE: sda_oe = 0; wait for STOP or START.
- nack_req is sampled only at the SCL fall that would begin ACK.
- sda_oe is never asserted outside ADDR_ACK/DATA_ACK.
- A START or STOP arriving while sda_oe = 1 releases SDA in the same cycle the event is detected.
- rx_data holds its value between strobes.
- rx_first and rx_is_data are meaningful only while rx_valid = 1; otherwise they are 0.

Optional Feature:
- Macro: I2C_CTRL_DECODE_EN.
- Defined: the first byte after the address is an SSD1306 control byte: bit7 = Co, bit6 = D/C#.
  - It is delivered with rx_first = 1, rx_is_data = 0.
  - If Co = 0: every following byte in the transfer is delivered with rx_is_data = D/C#.
  - If Co = 1: the next byte is a payload tagged with rx_is_data = D/C#, and the byte after it is again a control byte (rx_is_data = 0). The pattern repeats.
- Undefined: no decoding; rx_is_data tied 0; all bytes are delivered raw.

Test Plan:
- START, 0x78, 0x00, 0xAE, STOP
  - -> ACK (SDA low) on all three 9th clocks.
  - -> rx_valid twice: first 0x00 with rx_first = 1, then 0xAE with rx_first = 0.
  - -> start_det and stop_det each pulse once; busy returns to 0 after STOP.
- START, 0x7A (address 0x3D), 0x55, STOP -> sda_oe never 1, no rx_valid, busy stays 0.
- START, 0x79 (read to 0x3C) -> NACK; IGNORE until STOP; no rx_valid.
- Address ACKed, nack_req = 1 during second data byte 0x12
  - -> first byte ACKed and strobed.
  - -> second byte NACKed, no strobe.
  - -> later bytes ignored until START.
- Repeated START after 4 bits of a data byte, then 0x78, 0x40 -> partial byte discarded; fresh address ACK; 0x40 strobed with rx_first = 1.
- reset pulled low during ADDR_ACK with sda_oe = 1 -> sda_oe = 0 asynchronously; after release, state IDLE, no strobe.
  - With I2C_CTRL_DECODE_EN: stream 0x78, 0x40, 0xFF, 0x0F -> 0x40 delivered with rx_is_data = 0; 0xFF and 0x0F with rx_is_data = 1.
